scratchpad_arbiter: RTL and testbench
=====================================

Name: scratchpad_arbiter

Overview:
- Shares one scratchpad RAM port among NUM_REQ requesters, one transaction in flight at a time.
- Round-robin grant. Range and alignment checks against the scratchpad window. Sequences the RAM enable and read-latency wait, then returns a per-requester response with backpressure.
- Sits between the requester ports and the scratchpad's en/write/addr/len/wdata/rdata interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CHUNK_SIZE, 512, bytes per chunk.
- NUM_CHUNKS, 1024, chunk count; SP_SIZE = CHUNK_SIZE*NUM_CHUNKS bytes.
- SCRATCHPAD_BASE, 64'h0300000000000000, first valid byte address.
- RD_LATENCY, 1, cycles from sp_en to valid sp_rdata (1..4).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid per requester.
- req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready.
- req_write  in  NUM_REQ  1 = write.
- req_addr  in  NUM_REQ*64  absolute byte address, requester i at [64i+63:64i].
- req_len  in  NUM_REQ*2  size code: 00 byte, 01 half, 10 word, 11 double.
- req_wdata  in  NUM_REQ*64  write data.
- rsp_valid  out  NUM_REQ  response valid, at most one bit set.
- rsp_ready  in  NUM_REQ  response accept.
- rsp_err  out  1  response is an error; qualified by rsp_valid.
- rsp_rdata  out  64  read data; 0 for writes and errors.
- sp_en  out  1  scratchpad enable.
- sp_write  out  1  scratchpad write.
- sp_addr  out  64  absolute address to scratchpad.
- sp_len  out  2  size code to scratchpad.
- sp_wdata  out  64  write data to scratchpad.
- sp_rdata  in  64  scratchpad read data.
- err_count  out  16  saturating count of error responses.

Behaviour:
- Reset (async on rst_n=0):
  - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, sp_en=0, err_count=0.
  - Reset mid-transaction abandons it silently; no response is issued.
- IDLE:
  - req_ready = round-robin one-hot of req_valid, searching upward from rr_ptr with wrap-around. Combinational, asserted only in IDLE.
  - On handshake: capture write/addr/len/wdata and the requester index into registers; rr_ptr <= (index+1) mod NUM_REQ.
  - Error check on the captured request: off = addr - SCRATCHPAD_BASE (64-bit wrap).
    - Error if addr < SCRATCHPAD_BASE, or off + (1<<len) > SP_SIZE, or addr not aligned to 1<<len.
  - Error -> RESP with err=1; no sp_en is ever issued. Otherwise -> ACCESS.
  - No valid requests: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - sp_en=1, sp_write/addr/len/wdata from the captured registers.
  - Write -> RESP. Read -> WAIT with wait_cnt=RD_LATENCY.
- WAIT:
  - Decrement wait_cnt each cycle.
  - In the cycle where wait_cnt==1, register sp_rdata into rsp_rdata, then go to RESP.
- RESP:
  - rsp_valid[idx]=1, rsp_err and rsp_rdata held stable until rsp_ready[idx]=1, then -> IDLE.
  - rsp_ready on other bits is ignored.
- sp_en=0 and sp_write/sp_addr/sp_len/sp_wdata=0 in all states other than ACCESS.
- err_count increments on each error-response handshake and saturates at 16'hFFFF.
- Latency, with responder rsp_ready tied high:
  - read: handshake edge T, sp_en during T..T+1, rsp_valid at T+2+RD_LATENCY; new grant possible at T+3+RD_LATENCY.
  - write: rsp_valid at T+2.
  - error: rsp_valid at T+1.
- Simultaneous events:
  - New requests are not granted while any transaction is outstanding.
  - A requester may hold req_valid across its own RESP; it is eligible again once IDLE is reached, subject to rr_ptr.

Decomposition:
- Package scratchpad_pkg: len codes, state enum (IDLE/ACCESS/WAIT/RESP), SP_BASE_DEFAULT, a size-from-len function.
- One sub-module: rr_arbiter (parameter N; inputs req, ptr; output one-hot grant). It is reusable.
- Range and alignment check stays inline.

Test Plan:
- Single read: write 64'hDEADBEEF_CAFEF00D double to SCRATCHPAD_BASE+8 from req0, then read it back from req0 -> rsp_valid[0] with rsp_rdata=64'hDEADBEEF_CAFEF00D, rsp_err=0, latency 3 cycles at RD_LATENCY=1.
- Round-robin: all four req_valid held high with reads -> grant order 0,1,2,3,0. Dropping req1 gives 0,2,3,0.
- Range errors: addr=SCRATCHPAD_BASE-1 and addr=SCRATCHPAD_BASE+SP_SIZE-4 with len=11 -> rsp_err=1, rdata=0, sp_en never asserted, err_count=2.
- Misaligned: addr=SCRATCHPAD_BASE+2, len=10 -> error. Same addr with len=01 -> success.
- Response backpressure: hold rsp_ready[2]=0 for 5 cycles -> rsp_valid/rdata stable, no other grant. The new grant occurs the cycle after the accept.
- Reset mid-WAIT: pull rst_n low during WAIT -> all outputs 0 immediately, no response after release, rr_ptr=0.

Source files
------------

// File: rtl/scratchpad_pkg.sv
// Shared types and helpers for the scratchpad request arbiter.
// Size codes, FSM states and the default scratchpad window base.
package scratchpad_pkg;

    typedef enum logic [1:0] {
        LEN_BYTE   = 2'b00,
        LEN_HALF   = 2'b01,
        LEN_WORD   = 2'b10,
        LEN_DOUBLE = 2'b11
    } len_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } state_e;

    localparam logic [63:0] SP_BASE_DEFAULT = 64'h0300_0000_0000_0000;

    function automatic logic [63:0] size_from_len(input logic [1:0] len);
        return 64'd1 << len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request
// found searching upward from ptr, wrapping past N-1 back to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [2*N-1:0] w_shr;
    logic [2*N-1:0] w_shl;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_rot_gnt;

    // Rotate so that bit 0 of w_rot is requester ptr, pick the lowest set
    // bit there, then rotate the one-hot back into requester order.
    assign w_shr     = {req, {N{1'b0}}} >> ptr;
    assign w_rot_gnt = w_rot & (-w_rot);
    assign w_shl     = {{N{1'b0}}, w_rot_gnt} << ptr;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign w_rot[gi] = w_shr[gi] | w_shr[gi+N];
            assign grant[gi] = w_shl[gi] | w_shl[gi+N];
        end
    endgenerate

endmodule

// File: rtl/scratchpad_arbiter.sv
// Shares one scratchpad port among NUM_REQ requesters, one transaction at a
// time, with window/alignment checking and a held per-requester response.
module scratchpad_arbiter
    import scratchpad_pkg::*;
#(
    parameter int          NUM_REQ         = 4,
    parameter int          CHUNK_SIZE      = 512,
    parameter int          NUM_CHUNKS      = 1024,
    parameter logic [63:0] SCRATCHPAD_BASE = SP_BASE_DEFAULT,
    parameter int          RD_LATENCY      = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*64-1:0]   req_addr,
    input  logic [NUM_REQ*2-1:0]    req_len,
    input  logic [NUM_REQ*64-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic                    rsp_err,
    output logic [63:0]             rsp_rdata,
    output logic                    sp_en,
    output logic                    sp_write,
    output logic [63:0]             sp_addr,
    output logic [1:0]              sp_len,
    output logic [63:0]             sp_wdata,
    input  logic [63:0]             sp_rdata,
    output logic [15:0]             err_count
);

    localparam int          IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [64:0] SP_SIZE = 65'(CHUNK_SIZE) * 65'(NUM_CHUNKS);

    state_e             r_state;
    state_e             w_state_next;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic               r_write;
    logic [63:0]        r_addr;
    logic [1:0]         r_len;
    logic [63:0]        r_wdata;
    logic [2:0]         r_wait_cnt;
    logic               r_rsp_err;
    logic [63:0]        r_rsp_rdata;
    logic [15:0]        r_err_count;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [63:0]        w_addr_arr  [NUM_REQ];
    logic [63:0]        w_wdata_arr [NUM_REQ];
    logic [1:0]         w_len_arr   [NUM_REQ];
    logic [63:0]        w_sel_addr;
    logic [1:0]         w_sel_len;
    logic [63:0]        w_size;
    logic [63:0]        w_off;
    logic [64:0]        w_end;
    logic               w_req_err;
    logic               w_hs;
    logic               w_rsp_acc;
    logic               w_access;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = req_addr[64*gi +: 64];
            assign w_wdata_arr[gi] = req_wdata[64*gi +: 64];
            assign w_len_arr[gi]   = req_len[2*gi +: 2];
            assign rsp_valid[gi]   = (r_state == RESP) && (r_idx == IDX_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (IDX_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant)
    );

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    assign req_ready  = (r_state == IDLE) ? w_grant : '0;
    assign w_hs       = (r_state == IDLE) && (|w_grant);
    assign w_rsp_acc  = (r_state == RESP) && rsp_ready[r_idx];
    assign w_sel_addr = w_addr_arr[w_sel_idx];
    assign w_sel_len  = w_len_arr[w_sel_idx];

    // Offset end is computed one bit wider so an address near the top of
    // the 64-bit space cannot wrap back into the window.
    assign w_size    = size_from_len(w_sel_len);
    assign w_off     = w_sel_addr - SCRATCHPAD_BASE;
    assign w_end     = {1'b0, w_off} + {1'b0, w_size};
    assign w_req_err = (w_sel_addr < SCRATCHPAD_BASE) || (w_end > SP_SIZE)
                       || (|(w_sel_addr & (w_size - 64'd1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_state_next = w_req_err ? RESP : ACCESS;
            ACCESS:  w_state_next = r_write ? RESP : WAIT;
            WAIT:    if (r_wait_cnt == 3'd1) w_state_next = RESP;
            RESP:    if (w_rsp_acc) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_wdata     <= '0;
            r_wait_cnt  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_idx       <= w_sel_idx;
                        r_write     <= req_write[w_sel_idx];
                        r_addr      <= w_sel_addr;
                        r_len       <= w_sel_len;
                        r_wdata     <= w_wdata_arr[w_sel_idx];
                        r_rsp_err   <= w_req_err;
                        r_rsp_rdata <= '0;
                        r_rr_ptr    <= (w_sel_idx == IDX_W'(NUM_REQ - 1)) ?
                                       '0 : w_sel_idx + IDX_W'(1);
                    end
                end
                ACCESS: r_wait_cnt <= 3'(RD_LATENCY);
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 3'd1;
                    if (r_wait_cnt == 3'd1) begin
                        r_rsp_rdata <= sp_rdata;
                    end
                end
                RESP: begin
                    if (w_rsp_acc) begin
                        if (r_rsp_err && (r_err_count != 16'hFFFF)) begin
                            r_err_count <= r_err_count + 16'd1;
                        end
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_access  = (r_state == ACCESS);
    assign sp_en     = w_access;
    assign sp_write  = w_access ? r_write : 1'b0;
    assign sp_addr   = w_access ? r_addr  : '0;
    assign sp_len    = w_access ? r_len   : '0;
    assign sp_wdata  = w_access ? r_wdata : '0;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Randomized bench for scratchpad_arbiter: transaction-level reference model
// (grant order, error rules, latency, byte memory) plus a scratchpad model.
module tb_scratchpad_arbiter;

    localparam int          N       = 4;
    localparam int          RDL     = 1;
    localparam logic [63:0] BASE    = 64'h0300_0000_0000_0000;
    localparam logic [63:0] SP_SIZE = 64'd524288;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [N*64-1:0] req_addr, req_wdata;
    logic [N*2-1:0] req_len;
    logic           rsp_err, sp_en, sp_write;
    logic [63:0]    rsp_rdata, sp_addr, sp_wdata, sp_rdata;
    logic [1:0]     sp_len;
    logic [15:0]    err_count;

    scratchpad_arbiter #(
        .NUM_REQ(N), .CHUNK_SIZE(512), .NUM_CHUNKS(1024),
        .SCRATCHPAD_BASE(BASE), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .sp_en(sp_en), .sp_write(sp_write),
        .sp_addr(sp_addr), .sp_len(sp_len), .sp_wdata(sp_wdata),
        .sp_rdata(sp_rdata), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scratchpad model: byte array indexed by window offset, RDL=1 read.
    bit [7:0]    ram [524288];
    int          sp_en_cnt = 0;
    logic        last_write;
    logic [63:0] last_addr, last_wdata;
    logic [1:0]  last_len;

    function automatic logic [63:0] ram_read(input logic [63:0] a, input logic [1:0] len);
        logic [63:0] d = '0;
        for (int b = 0; b < (1 << len); b++) d[8*b +: 8] = ram[19'(a[18:0] + 19'(b))];
        return d;
    endfunction

    always @(posedge clk) begin
        if (sp_en) begin
            sp_en_cnt  <= sp_en_cnt + 1;
            last_write <= sp_write;
            last_addr  <= sp_addr;
            last_len   <= sp_len;
            last_wdata <= sp_wdata;
            if (sp_write) begin
                for (int b = 0; b < (1 << sp_len); b++)
                    ram[19'(sp_addr[18:0] + 19'(b))] <= sp_wdata[8*b +: 8];
            end else begin
                sp_rdata <= ram_read(sp_addr, sp_len);
            end
        end else begin
            sp_rdata <= {$urandom, $urandom};
        end
    end

    // Reference model state.
    bit [7:0]    ref_mem [524288];
    int          m_ptr;
    int          m_err;
    logic        t_write [N];
    logic [63:0] t_addr  [N];
    logic [1:0]  t_len   [N];
    logic [63:0] t_wdata [N];

    function automatic int model_grant(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++)
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [63:0] a,
                           input logic [1:0] l, input logic [63:0] d);
        t_write[i] = w; t_addr[i] = a; t_len[i] = l; t_wdata[i] = d;
    endtask

    // One arbitration round, starting and ending at posedge+1 in IDLE.
    task automatic run_round(input logic [N-1:0] mask, input int bp, output logic [63:0] obs);
        int g, k, en0, exp_lat;
        bit e;
        logic [63:0] size, off, exp_rd;
        logic [N-1:0] oh;
        obs = '0;
        for (int i = 0; i < N; i++) begin
            req_write[i] = t_write[i];
            req_addr[64*i +: 64] = t_addr[i];
            req_len[2*i +: 2] = t_len[i];
            req_wdata[64*i +: 64] = t_wdata[i];
        end
        req_valid = mask;
        #1;
        g  = model_grant(mask, m_ptr);
        oh = (g < 0) ? '0 : N'(1) << g;
        check_eq("grant", req_ready, oh);
        if (g < 0) begin
            @(posedge clk); #1;
            return;
        end
        size = 64'd1 << t_len[g];
        off  = t_addr[g] - BASE;
        e    = (t_addr[g] < BASE) || (off + size > SP_SIZE) || (t_addr[g] % size != 0);
        exp_rd = '0;
        if (!e) begin
            for (int b = 0; b < int'(size); b++) begin
                if (t_write[g]) ref_mem[off + b] = t_wdata[g][8*b +: 8];
                else exp_rd = exp_rd | (64'(ref_mem[off + b]) << (8 * b));
            end
        end
        exp_lat   = e ? 1 : (t_write[g] ? 2 : 2 + RDL);
        en0       = sp_en_cnt;
        rsp_ready = (bp > 0) ? ~oh : '1;
        @(posedge clk); #1;
        req_valid = ~oh;
        m_ptr = (g + 1) % N;
        k = 1;
        while (rsp_valid == '0 && k < 12) begin
            check_eq("busy_ready", req_ready, '0);
            if (!sp_en) check_eq("sp_idle", (sp_addr | sp_wdata) | {61'b0, sp_write, sp_len}, '0);
            @(posedge clk); #1;
            k++;
        end
        check_eq("latency", k, exp_lat);
        check_eq("rsp_valid", rsp_valid, oh);
        check_eq("rsp_err", rsp_err, e);
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        obs = rsp_rdata;
        check_eq("sp_en_count", sp_en_cnt - en0, e ? 0 : 1);
        if (!e) begin
            check_eq("sp_addr", last_addr, t_addr[g]);
            check_eq("sp_cmd", {last_write, last_len}, {t_write[g], t_len[g]});
            if (t_write[g]) check_eq("sp_wdata", last_wdata, t_wdata[g]);
        end
        for (int c = 0; c < bp; c++) begin
            @(posedge clk); #1;
            check_eq("bp_valid", rsp_valid, oh);
            check_eq("bp_rdata", rsp_rdata, exp_rd);
            check_eq("bp_ready", req_ready, '0);
        end
        rsp_ready = '1;
        @(posedge clk); #1;
        if (e && m_err < 65535) m_err++;
        check_eq("err_count", err_count, m_err);
        check_eq("rsp_done", rsp_valid, '0);
    endtask

    function automatic logic [63:0] rand_addr();
        int r = $urandom_range(0, 11);
        if (r == 0) return BASE - 64'($urandom_range(1, 16));
        if (r == 1) return BASE + SP_SIZE - 64'($urandom_range(0, 16));
        return BASE + 64'($urandom_range(0, 63));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] obs;
        rst_n = 1'b0; req_valid = '0; rsp_ready = '1; req_write = '0;
        req_addr = '0; req_len = '0; req_wdata = '0;
        m_ptr = 0; m_err = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, BASE, 2'd0, '0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", req_ready, '0);
        check_eq("rst_rsp_valid", rsp_valid, '0);
        check_eq("rst_rsp", {63'b0, rsp_err} | rsp_rdata, '0);
        check_eq("rst_sp_en", sp_en, 0);
        check_eq("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_req(0, 1'b1, BASE + 8, 2'd3, 64'hDEADBEEF_CAFEF00D);
        run_round(4'b0001, 0, obs);
        set_req(0, 1'b0, BASE + 8, 2'd3, '0);
        run_round(4'b0001, 0, obs);
        check_eq("readback", obs, 64'hDEADBEEF_CAFEF00D);

        for (int i = 0; i < N; i++) set_req(i, 1'b0, BASE + 64'(8 * i), 2'd3, '0);
        repeat (5) run_round(4'b1111, 0, obs);
        repeat (4) run_round(4'b1101, 0, obs);

        set_req(1, 1'b0, BASE - 1, 2'd3, '0);
        run_round(4'b0010, 0, obs);
        set_req(1, 1'b0, BASE + SP_SIZE - 4, 2'd3, '0);
        run_round(4'b0010, 0, obs);
        set_req(3, 1'b1, BASE + 2, 2'd2, 64'h1111_2222_3333_4444);
        run_round(4'b1000, 0, obs);
        set_req(3, 1'b1, BASE + 2, 2'd1, 64'h0000_0000_0000_ABCD);
        run_round(4'b1000, 0, obs);
        set_req(3, 1'b0, BASE + 2, 2'd1, '0);
        run_round(4'b1000, 0, obs);

        set_req(2, 1'b0, BASE + 8, 2'd3, '0);
        run_round(4'b0100, 5, obs);

        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), rand_addr(),
                        2'($urandom_range(0, 3)), {$urandom, $urandom});
            run_round(4'($urandom_range(1, 15)),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, obs);
        end

        // Abort a read while it waits for the scratchpad.
        set_req(0, 1'b0, BASE + 16, 2'd3, '0);
        req_addr[63:0] = BASE + 16; req_len[1:0] = 2'd3; req_write[0] = 1'b0;
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = '0;
        check_eq("abort_access", sp_en, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_rsp_valid", rsp_valid, '0);
        check_eq("abort_sp_en", sp_en, 0);
        check_eq("abort_ready", req_ready, '0);
        check_eq("abort_err_count", err_count, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_eq("abort_no_rsp", rsp_valid, '0);
        end
        m_ptr = 0; m_err = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, BASE + 64'(8 * i), 2'd3, '0);
        run_round(4'b1111, 0, obs);
        run_round(4'b1111, 0, obs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
